// File: rtl/ppu_pkg.sv
// Shared PPU definitions: op codes, request bundle and op legality.
// Imported by the issue queue, its FIFO and the pipeline control FSM.
package ppu_pkg;

    localparam int OP_SIZE = 3;
    localparam int POSIT_N = 16;

    typedef enum logic [OP_SIZE-1:0] {
        ADD            = 3'd0,
        SUB            = 3'd1,
        MUL            = 3'd2,
        DIV            = 3'd3,
        FLOAT_TO_POSIT = 3'd4,
        POSIT_TO_FLOAT = 3'd5
    } ppu_op_t;

    typedef struct packed {
        logic [OP_SIZE-1:0] op;
        logic [POSIT_N-1:0] a;
        logic [POSIT_N-1:0] b;
    } ppu_req_t;

    // Codes 6 and 7 are unassigned and must never reach the pipeline.
    function automatic logic is_legal_op(input logic [OP_SIZE-1:0] op);
        return (op <= POSIT_TO_FLOAT);
    endfunction

endpackage

// File: rtl/ppu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO of request bundles.
// Push while full and pop while empty are ignored.
module ppu_sync_fifo
    import ppu_pkg::*;
#(
    parameter type T     = ppu_req_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  T                         wdata_i,
    output T                         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ppu_issue_queue.sv
// Input-side buffer of the PPU: queues core requests and presents the head
// to the pipeline FSM, holding it while the FSM stalls.
module ppu_issue_queue #(
    parameter int OP_SIZE = 3,
    parameter int N       = 16,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [OP_SIZE-1:0]       in_op_i,
    input  logic [N-1:0]             in_a_i,
    input  logic [N-1:0]             in_b_i,
    input  logic                     stall_i,
    output logic                     out_valid_o,
    output logic [OP_SIZE-1:0]       out_op_o,
    output logic [N-1:0]             out_a_o,
    output logic [N-1:0]             out_b_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);

    import ppu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [OP_SIZE-1:0] op;
        logic [N-1:0]       a;
        logic [N-1:0]       b;
    } req_t;

    req_t           wr_req, head_req;
    logic           fifo_full, fifo_empty;
    logic           accept, legal, push, pop;
    logic           err_q, err_d;
    logic [CW-1:0]  fifo_count;

    // Ready is a function of occupancy only, so stall_i never reaches it.
    assign in_ready_o = !rst && !fifo_full;
    assign accept     = in_valid_i && in_ready_o;
    assign legal      = is_legal_op(in_op_i);
    assign push       = accept && legal;
    assign err_d      = accept && !legal;

    assign out_valid_o = !rst && !fifo_empty;
    assign pop         = out_valid_o && !stall_i;

    assign wr_req = '{op: in_op_i, a: in_a_i, b: in_b_i};

    ppu_sync_fifo #(
        .T     (req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_req),
        .rdata_o (head_req),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    // Unwritten slots may hold stale data; never let it show while empty.
    assign out_op_o = out_valid_o ? head_req.op : '0;
    assign out_a_o  = out_valid_o ? head_req.a  : '0;
    assign out_b_o  = out_valid_o ? head_req.b  : '0;
    assign count_o  = fifo_count;
    assign err_o    = err_q;

endmodule

// File: tb/tb_ppu_issue_queue.sv
// Directed bench for ppu_issue_queue: a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_ppu_issue_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a, in_b;
    logic        stall;
    logic        out_valid;
    logic [2:0]  out_op;
    logic [15:0] out_a, out_b;
    logic [2:0]  count;
    logic        err;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    ppu_issue_queue #(.OP_SIZE(3), .N(16), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .stall_i     (stall),
        .out_valid_o (out_valid),
        .out_op_o    (out_op),
        .out_a_o     (out_a),
        .out_b_o     (out_b),
        .count_o     (count),
        .err_o       (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted requests.
    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } ent_t;

    ent_t mq[$];
    logic m_err = 1'b0;

    always @(posedge clk) begin : model
        int  sz;
        bit  acc, leg, pp;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_err <= 1'b0;
        end else begin
            sz  = mq.size();
            acc = in_valid && (sz < DEPTH);
            leg = (in_op <= 3'd5);
            pp  = (sz > 0) && !stall;
            m_err <= acc && !leg;
            if (pp) void'(mq.pop_front());
            if (acc && leg) begin
                e.op = in_op; e.a = in_a; e.b = in_b;
                mq.push_back(e);
                $display("push op=%0d a=%h b=%h", in_op, in_a, in_b);
            end else if (acc) begin
                $display("drop illegal op=%0d", in_op);
            end
        end
    end

    always @(negedge clk) begin : compare
        int sz;
        bit ev;
        if (check_en) begin
            sz = mq.size();
            ev = !rst && (sz > 0);
            chk("m_out_valid", out_valid, ev);
            chk("m_in_ready", in_ready, !rst && (sz < DEPTH));
            chk("m_count", count, sz);
            chk("m_err", err, m_err);
            if (ev) begin
                chk("m_out_op", out_op, mq[0].op);
                chk("m_out_a", out_a, mq[0].a);
                chk("m_out_b", out_b, mq[0].b);
            end else begin
                chk("m_out_zero", {out_op, out_a, out_b}, '0);
            end
        end
    end

    // One cycle of stimulus: apply just after posedge, return at the next negedge.
    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic st, input logic r);
        @(posedge clk);
        #1;
        in_valid = v; in_op = op; in_a = a; in_b = b; stall = st; rst = r;
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        drive(1'b0, 3'd0, 16'h0, 16'h0, st, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;

        // Reset then idle
        idle(1'b0);
        idle(1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_count", count, 3'd0);
        chk("rst_outs", {out_op, out_a, out_b}, '0);

        // Single push, one-cycle latency, immediate pop
        drive(1'b1, 3'd0, 16'h4000, 16'h3800, 1'b0, 1'b0);
        chk("lat_not_bypassed", out_valid, 1'b0);
        idle(1'b0);
        chk("single_valid", out_valid, 1'b1);
        chk("single_op", out_op, 3'd0);
        chk("single_a", out_a, 16'h4000);
        chk("single_b", out_b, 16'h3800);
        idle(1'b0);
        chk("single_drained_cnt", count, 3'd0);
        chk("single_drained_vld", out_valid, 1'b0);

        // Fill under stall, fifth op held by the source
        drive(1'b1, 3'd0, 16'h0101, 16'h1010, 1'b1, 1'b0);
        drive(1'b1, 3'd1, 16'h0202, 16'h2020, 1'b1, 1'b0);
        drive(1'b1, 3'd2, 16'h0303, 16'h3030, 1'b1, 1'b0);
        drive(1'b1, 3'd3, 16'h0404, 16'h4040, 1'b1, 1'b0);
        drive(1'b1, 3'd0, 16'h0505, 16'h5050, 1'b1, 1'b0);
        chk("full_count", count, 3'd4);
        chk("full_ready", in_ready, 1'b0);
        chk("full_head_held", out_a, 16'h0101);
        drive(1'b1, 3'd0, 16'h0505, 16'h5050, 1'b0, 1'b0);
        chk("order0", out_op, 3'd0);
        chk("full_no_push_on_pop", in_ready, 1'b0);
        drive(1'b1, 3'd0, 16'h0505, 16'h5050, 1'b0, 1'b0);
        chk("order1", out_op, 3'd1);
        chk("after_pop_count", count, 3'd3);
        idle(1'b0);
        chk("order2", out_op, 3'd2);
        chk("pushpop_count", count, 3'd3);
        idle(1'b0);
        chk("order3", out_op, 3'd3);
        idle(1'b0);
        chk("order4", out_op, 3'd0);
        chk("order4_a", out_a, 16'h0505);
        idle(1'b0);
        chk("order_drained", out_valid, 1'b0);

        // One-cycle stall on MUL after DIV
        drive(1'b1, 3'd3, 16'h1111, 16'h2222, 1'b1, 1'b0);
        drive(1'b1, 3'd2, 16'h3333, 16'h4444, 1'b1, 1'b0);
        idle(1'b0);
        chk("div_head", out_op, 3'd3);
        chk("div_count", count, 3'd2);
        idle(1'b1);
        chk("mul_stall_op", out_op, 3'd2);
        chk("mul_stall_cnt", count, 3'd1);
        idle(1'b0);
        chk("mul_held_op", out_op, 3'd2);
        chk("mul_held_a", out_a, 16'h3333);
        chk("mul_held_cnt", count, 3'd1);
        idle(1'b0);
        chk("mul_popped", count, 3'd0);

        // Illegal op is dropped with a one-cycle err pulse
        drive(1'b1, 3'd4, 16'h7777, 16'h8888, 1'b1, 1'b0);
        drive(1'b1, 3'd6, 16'hdead, 16'hbeef, 1'b1, 1'b0);
        chk("ill_err_before", err, 1'b0);
        idle(1'b1);
        chk("ill_err_pulse", err, 1'b1);
        chk("ill_count", count, 3'd1);
        chk("ill_valid", out_valid, 1'b1);
        chk("ill_head", out_op, 3'd4);
        idle(1'b1);
        chk("ill_err_cleared", err, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("ill_drained", count, 3'd0);

        // Reset mid-operation with a pending offer
        drive(1'b1, 3'd1, 16'haaaa, 16'h0001, 1'b1, 1'b0);
        drive(1'b1, 3'd1, 16'hbbbb, 16'h0002, 1'b1, 1'b0);
        drive(1'b1, 3'd1, 16'hcccc, 16'h0003, 1'b1, 1'b0);
        idle(1'b1);
        chk("pre_rst_count", count, 3'd3);
        drive(1'b1, 3'd5, 16'h9999, 16'h9999, 1'b1, 1'b1);
        chk("in_rst_ready", in_ready, 1'b0);
        chk("in_rst_valid", out_valid, 1'b0);
        drive(1'b1, 3'd2, 16'h1234, 16'h5678, 1'b0, 1'b0);
        chk("post_rst_count", count, 3'd0);
        chk("post_rst_valid", out_valid, 1'b0);
        idle(1'b0);
        chk("post_rst_head_op", out_op, 3'd2);
        chk("post_rst_head_a", out_a, 16'h1234);
        chk("post_rst_head_b", out_b, 16'h5678);
        chk("post_rst_cnt1", count, 3'd1);
        idle(1'b0);
        idle(1'b0);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
